read_return_arbiter: RTL and testbench

- Parametrised, registered successor to the SoC read-data return mux: collects read responses from N slave peripherals (RAM, IO, UART, timer, SDRAM, sound, SD-card SPI, ...) and forwards one per cycle to the CPU data-in port.
- Unlike a pure one-hot mux, it tolerates simultaneous valids: each channel has a one-deep pending slot, and slots drain round-robin. Drops are reported via a sticky overflow flag.
- Sits between the slave read-data buses and the CPU load path.

---
 rtl/soc_bus_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/read_return_arbiter.sv | 106 ++++++++++
 tb/tb_read_return_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: default return-path sizing, slave channel
// indices and the round-robin pointer advance rule.
package soc_bus_pkg;

    localparam int SOC_CHANNELS   = 11;
    localparam int SOC_DATA_WIDTH = 32;

    localparam int CH_RAM        = 0;
    localparam int CH_IO         = 1;
    localparam int CH_UART       = 2;
    localparam int CH_RANDOM     = 3;
    localparam int CH_TIMER      = 4;
    localparam int CH_SDRAM      = 5;
    localparam int CH_SEQUENCER  = 6;
    localparam int CH_SAMPLE     = 7;
    localparam int CH_DACSPI     = 8;
    localparam int CH_SOUND      = 9;
    localparam int CH_SDCARDSPI  = 10;

    typedef logic [SOC_CHANNELS-1:0] chan_mask_t;

    // Pointer moves one past the winner so the winner becomes lowest priority.
    function automatic int rr_next(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer wins, otherwise the first set request below it.
module rr_arbiter #(
    parameter int CHANNELS = 11,
    parameter int ID_WIDTH = 4
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [CHANNELS-1:0] o_grant,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any
);

    always_comb begin
        logic w_found;
        w_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        // Two ascending passes give the wrapped search order without modulo.
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && i_req[i] && (i >= int'(i_ptr))) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = ID_WIDTH'(i);
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && i_req[i] && (i < int'(i_ptr))) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                o_idx      = ID_WIDTH'(i);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/read_return_arbiter.sv
// Registered read-data return arbiter: one-deep pending slot per slave
// channel, round-robin drain to the CPU, sticky overflow on dropped data.
module read_return_arbiter
    import soc_bus_pkg::*;
#(
    parameter int CHANNELS   = SOC_CHANNELS,
    parameter int DATA_WIDTH = SOC_DATA_WIDTH,
    parameter int ID_WIDTH   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [CHANNELS-1:0]            slaveValid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] slaveData,
    input  logic                           overflowClear,
    output logic                           readValid,
    output logic [DATA_WIDTH-1:0]          dataIn,
    output logic [ID_WIDTH-1:0]            sourceId,
    output logic                           pendingAny,
    output logic                           overflow,
    output logic [CHANNELS-1:0]            overflowMask
);

    logic [CHANNELS-1:0]   r_pend;
    logic [DATA_WIDTH-1:0] r_pend_data [CHANNELS];
    logic [ID_WIDTH-1:0]   r_ptr;

    logic [CHANNELS-1:0]   w_cand;
    logic [CHANNELS-1:0]   w_grant;
    logic [CHANNELS-1:0]   w_pend_nxt;
    logic [CHANNELS-1:0]   w_load;
    logic [CHANNELS-1:0]   w_drop;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_any;
    logic [DATA_WIDTH-1:0] w_gdata;

    assign w_cand = r_pend | slaveValid;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .i_req   (w_cand),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_gdata    = '0;
        w_pend_nxt = '0;
        w_load     = '0;
        w_drop     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_grant[i]) begin
                w_gdata = w_gdata | (r_pend[i] ? r_pend_data[i]
                                               : slaveData[i*DATA_WIDTH +: DATA_WIDTH]);
            end
            // Slot loads on a reload after draining, or on a fresh capture.
            w_load[i]     = slaveValid[i] & (w_grant[i] == r_pend[i]);
            w_drop[i]     = slaveValid[i] & r_pend[i] & ~w_grant[i];
            w_pend_nxt[i] = w_grant[i] ? (r_pend[i] & slaveValid[i])
                                       : (r_pend[i] | slaveValid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_pend_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_load[i]) begin
                    r_pend_data[i] <= slaveData[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend       <= '0;
            r_ptr        <= '0;
            readValid    <= 1'b0;
            dataIn       <= '0;
            sourceId     <= '0;
            pendingAny   <= 1'b0;
            overflow     <= 1'b0;
            overflowMask <= '0;
        end else begin
            r_pend     <= w_pend_nxt;
            readValid  <= w_any;
            dataIn     <= w_gdata;
            sourceId   <= w_idx;
            pendingAny <= |w_pend_nxt;
            if (w_any) begin
                r_ptr <= ID_WIDTH'(rr_next(int'(w_idx), CHANNELS));
            end
            // A drop coinciding with a clear still leaves the flag set.
            overflowMask <= (overflowClear ? '0 : overflowMask) | w_drop;
            overflow     <= (overflow & ~overflowClear) | (|w_drop);
        end
    end

endmodule

// File: tb/tb_read_return_arbiter.sv
// Self-checking bench for read_return_arbiter: directed scenarios plus
// randomized traffic against a per-channel slot reference model.
module tb_read_return_arbiter;
    import soc_bus_pkg::*;

    localparam int CH  = SOC_CHANNELS;
    localparam int DW  = SOC_DATA_WIDTH;
    localparam int IDW = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH-1:0]     sv = '0;
    logic [CH*DW-1:0]  sd = '0;
    logic              clr = 1'b0;
    logic              readValid;
    logic [DW-1:0]     dataIn;
    logic [IDW-1:0]    sourceId;
    logic              pendingAny;
    logic              overflow;
    logic [CH-1:0]     overflowMask;

    read_return_arbiter #(
        .CHANNELS   (CH),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .slaveValid    (sv),
        .slaveData     (sd),
        .overflowClear (clr),
        .readValid     (readValid),
        .dataIn        (dataIn),
        .sourceId      (sourceId),
        .pendingAny    (pendingAny),
        .overflow      (overflow),
        .overflowMask  (overflowMask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [CH-1:0] m_pend;
    logic [DW-1:0] m_data [CH];
    int            m_ptr;
    logic          m_ovf;
    logic [CH-1:0] m_mask;
    logic          e_valid;
    logic [DW-1:0] e_data;
    int            e_id;
    logic          e_pany;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_ptr   = 0;
        m_ovf   = 1'b0;
        m_mask  = '0;
        e_valid = 1'b0;
        e_data  = '0;
        e_id    = 0;
        e_pany  = 1'b0;
        for (int i = 0; i < CH; i++) m_data[i] = '0;
    endtask

    task automatic model_step();
        int            g;
        logic [CH-1:0] drop;
        logic [DW-1:0] dv;
        g    = -1;
        drop = '0;
        for (int k = 0; k < CH; k++) begin
            if (g < 0 && (m_pend[(m_ptr + k) % CH] || sv[(m_ptr + k) % CH]))
                g = (m_ptr + k) % CH;
        end
        if (g >= 0) begin
            e_valid = 1'b1;
            e_id    = g;
            e_data  = m_pend[g] ? m_data[g] : sd[g*DW +: DW];
            m_ptr   = (g + 1) % CH;
        end else begin
            e_valid = 1'b0;
            e_id    = 0;
            e_data  = '0;
        end
        for (int i = 0; i < CH; i++) begin
            dv = sd[i*DW +: DW];
            if (i == g) begin
                if (m_pend[i] && sv[i]) m_data[i] = dv;
                else m_pend[i] = 1'b0;
            end else if (sv[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1'b1;
                    m_data[i] = dv;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
        if (clr) begin
            m_ovf  = 1'b0;
            m_mask = '0;
        end
        if (drop != '0) begin
            m_ovf  = 1'b1;
            m_mask = m_mask | drop;
        end
        e_pany = (m_pend != '0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("readValid", readValid, e_valid);
        check_eq("dataIn", dataIn, e_data);
        check_eq("sourceId", sourceId, e_id);
        check_eq("pendingAny", pendingAny, e_pany);
        check_eq("overflow", overflow, m_ovf);
        check_eq("overflowMask", overflowMask, m_mask);
    endtask

    task automatic set_ch(input int i, input logic [DW-1:0] d);
        sv[i] = 1'b1;
        sd[i*DW +: DW] = d;
    endtask

    // Asserts reset between clock edges, checks outputs cleared at once.
    task automatic apply_reset();
        sv = '0;
        clr = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_readValid", readValid, 0);
        check_eq("rst_dataIn", dataIn, 0);
        check_eq("rst_sourceId", sourceId, 0);
        check_eq("rst_pendingAny", pendingAny, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_overflowMask", overflowMask, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        apply_reset();

        // single response
        set_ch(CH_TIMER, 32'hDEADBEEF);
        cycle();
        check_eq("t1_valid", readValid, 1);
        check_eq("t1_data", dataIn, 32'hDEADBEEF);
        check_eq("t1_id", sourceId, 4);
        sv = '0;
        cycle();
        check_eq("t1_idle_valid", readValid, 0);
        check_eq("t1_idle_pend", pendingAny, 0);

        // simultaneous responses from ptr=0
        apply_reset();
        set_ch(0, 32'h11);
        set_ch(5, 32'h55);
        set_ch(10, 32'hAA);
        cycle();
        check_eq("t2_id0", sourceId, 0);
        check_eq("t2_d0", dataIn, 32'h11);
        sv = '0;
        cycle();
        check_eq("t2_id1", sourceId, 5);
        check_eq("t2_d1", dataIn, 32'h55);
        cycle();
        check_eq("t2_id2", sourceId, 10);
        check_eq("t2_d2", dataIn, 32'hAA);
        check_eq("t2_pend_done", pendingAny, 0);
        set_ch(3, 32'h33);
        set_ch(9, 32'h99);
        cycle();
        check_eq("t2_wrap_id", sourceId, 3);
        sv = '0;
        cycle();
        cycle();

        // fairness: channels 1 and 2 every cycle
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            sv = '0;
            set_ch(1, $urandom);
            set_ch(2, $urandom);
            cycle();
            check_eq("t3_alt_id", sourceId, (c % 2 == 0) ? 1 : 2);
        end
        sv = '0;
        cycle();
        cycle();
        check_eq("t3_ovf", overflow, 1);
        check_eq("t3_mask", overflowMask, 11'h006);

        // overflow on channel 3 blocked behind channel 2
        apply_reset();
        set_ch(1, 32'h1111);
        set_ch(3, 32'h3333);
        cycle();
        sv = '0;
        set_ch(2, 32'h2222);
        set_ch(3, 32'h3334);
        cycle();
        check_eq("t4_id2", sourceId, 2);
        sv = '0;
        cycle();
        check_eq("t4_old_data", dataIn, 32'h3333);
        check_eq("t4_old_id", sourceId, 3);
        check_eq("t4_ovf", overflow, 1);
        check_eq("t4_mask", overflowMask, 11'h008);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_eq("t4_clr_ovf", overflow, 0);
        check_eq("t4_clr_mask", overflowMask, 0);
        set_ch(5, 32'h5555);
        set_ch(3, 32'h3335);
        cycle();
        sv = '0;
        set_ch(7, 32'h7777);
        set_ch(3, 32'h3336);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_eq("t4_clrdrop_ovf", overflow, 1);
        check_eq("t4_clrdrop_mask", overflowMask, 11'h008);
        sv = '0;
        cycle();
        cycle();

        // async reset mid-drain with three slots pending
        apply_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'hC0 + i);
        cycle();
        check_eq("t5_pending", pendingAny, 1);
        apply_reset();
        cycle();
        check_eq("t5_no_stale", readValid, 0);
        cycle();
        check_eq("t5_no_stale2", readValid, 0);
        set_ch(6, 32'h6666);
        cycle();
        check_eq("t5_lat_valid", readValid, 1);
        check_eq("t5_lat_id", sourceId, 6);
        sv = '0;
        cycle();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            sv  = CH'($urandom & $urandom);
            for (int i = 0; i < CH; i++) sd[i*DW +: DW] = $urandom;
            clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        sv = '0;
        clr = 1'b0;
        for (int c = 0; c < CH + 1; c++) cycle();
        check_eq("final_drained", pendingAny, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
